ws2812_rx: RTL and testbench
============================

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
  CLK_FRE  25_175_000  clock frequency in Hz
  T_BIT_THRESH  15  high-pulse length in cycles; a count above this decodes as 1, at or below it as 0 (about 600 ns)
  T_HIGH_MAX  50  longest legal high pulse in cycles (about 2 us)
  T_RESET  1259  low time in cycles that ends a frame (about 50 us)
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
  clk_i  in  1  system clock
  rst_i  in  1  reset
  R_W_n  in  1  CPU read/write strobe; 0 = write
  reg_addr_i  in  2  register select
  data_i  in  8  CPU write data
  rx_cs  in  1  chip select for this IO page
  ws2812_in  in  1  WS2812 serial line, asynchronous to clk_i
  data_o  out  8  registered read data
  irq_o  out  1  level interrupt; equals status[0] OR status[1]
REQ-003 The block SHALL use one clock, clk_i; reset rst_i SHALL be asynchronous and active-high.

Function
REQ-004 ws2812_in SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized signal only.
REQ-005 Rising and falling edges SHALL be detected by comparing the synchronized signal with its 1-cycle-delayed copy.
REQ-006 A single 16-bit counter SHALL count cycles since the last edge, reset to 0 on each edge, and saturate at 16'hFFFF.
REQ-007 The FSM SHALL have states WAIT_RESET, IDLE, HIGH and LOW, with these transitions:
  WAIT_RESET -> IDLE once the line has been low for T_RESET cycles
  IDLE -> HIGH on a rising edge
  HIGH -> LOW on a falling edge
  LOW -> HIGH on a rising edge
  LOW -> IDLE when the low count reaches T_RESET (end of frame)
REQ-008 On each HIGH->LOW transition, the decoded bit SHALL be 1 if the high count exceeds T_BIT_THRESH and 0 otherwise.
REQ-009 Decoded bits SHALL shift MSB-first into a 24-bit word register, and a 5-bit bit counter SHALL track the position.
REQ-010 At the 24th bit, the bit counter SHALL wrap to 0 and an 8-bit word counter SHALL increment, saturating at 255.
REQ-011 Word bits SHALL map in wire order: [23:16] = G, [15:8] = R, [7:0] = B.
REQ-012 The first complete word of a frame (word counter 0 -> 1) SHALL be copied into g_reg, r_reg and b_reg in the cycle after the 24th falling edge.
REQ-013 Later words in the same frame SHALL be decoded and counted, but SHALL NOT update the colour registers.
REQ-014 At end of frame, status[0] (valid) SHALL be set if the word counter is nonzero; the bit and word counters SHALL then clear.
REQ-015 status[1] (error) SHALL be set in either of these cases:
  the high count exceeds T_HIGH_MAX; the FSM then goes to WAIT_RESET and the partial word is discarded
  a frame ends with a nonzero bit counter; the partial word is discarded, and valid still follows REQ-014
REQ-016 status[2] (busy) SHALL be 1 in states HIGH and LOW; status[7:3] SHALL read 0.
REQ-017 The register map SHALL be:
  0: status; writing 1 to bits [1:0] clears them (write-1-to-clear)
  1: r_reg, read-only
  2: g_reg, read-only
  3: b_reg, read-only
  Writes to addresses 1 to 3 SHALL be ignored.
REQ-018 If a hardware set and a CPU clear of the same status bit occur in the same cycle, the set SHALL win.
REQ-019 data_o SHALL be registered, presenting the register selected by reg_addr_i one cycle later, independent of rx_cs.
REQ-020 A rising edge in WAIT_RESET SHALL restart the low-time requirement; no bits are decoded in this state.

Reset
REQ-021 While rst_i is high, the FSM SHALL be in WAIT_RESET, and all counters, the word register, status, r_reg, g_reg, b_reg and data_o SHALL be 0.
REQ-022 Both synchronizer flops SHALL reset to 0, and irq_o SHALL be 0.
REQ-023 Releasing rst_i in the middle of a frame SHALL NOT decode the frame tail; decoding starts only after a T_RESET low period.

Verification
REQ-024 The bench SHALL cover these directed scenarios (stimulus -> required response):
  1. Reset, then line low 1300 cycles, then one word G=0x12, R=0x34, B=0x56 (1 = 21 high/10 low, 0 = 10 high/21 low), then low 1300 cycles -> r/g/b read 0x34/0x12/0x56; status = 0x01; irq_o = 1.
  2. Write 0x01 to address 0 -> status = 0x00; irq_o = 0 the next cycle.
  3. Three-word frame A5A5A5, FFFFFF, 000000 -> g/r/b = A5/A5/A5; valid set.
  4. Frame of 30 bits -> first word captured; status = 0x03.
  5. 60-cycle high pulse -> status[1] = 1, no register update; the next clean frame decodes correctly.
  6. rst_i asserted mid-word, released while the line is toggling -> nothing decoded until 1259 low cycles have passed; all reads return 0 until then.

Source files
------------

// File: rtl/ws2812_rx.sv
// WS2812 serial receiver: decodes GRB words from a single-wire stream and
// exposes the first word of each frame through a small CPU register page.
module ws2812_rx #(
  parameter int CLK_FRE      = 25_175_000,
  parameter int T_BIT_THRESH = 15,
  parameter int T_HIGH_MAX   = 50,
  parameter int T_RESET      = 1259
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       R_W_n,
  input  logic [1:0] reg_addr_i,
  input  logic [7:0] data_i,
  input  logic       rx_cs,
  input  logic       ws2812_in,
  output logic [7:0] data_o,
  output logic       irq_o
);

  typedef enum logic [1:0] {WAIT_RESET, IDLE, HIGH, LOW} state_e;

  logic        sync1_q, sync2_q, prev_q;
  logic        rise, fall;
  logic [15:0] cnt_q, cnt_d;
  state_e      state_q, state_d;
  logic [4:0]  bit_cnt_q;
  logic [7:0]  word_cnt_q;
  logic [23:0] word_q;
  logic        cap_q;
  logic [7:0]  r_q, g_q, b_q;
  logic        valid_q, valid_d, err_q, err_d;
  logic [7:0]  data_q, data_d;
  logic        bit_strb, eof_strb, long_err, busy;
  logic        too_long, frame_gap, st_clr;

  // Only data_i[1:0] is meaningful (W1C); CLK_FRE documents timing only.
  logic unused_ok;
  assign unused_ok = ^{data_i[7:2], 32'(CLK_FRE)};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= ws2812_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (rise || fall)        cnt_d = 16'd0;
    else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

  assign too_long  = cnt_q > 16'(T_HIGH_MAX);
  assign frame_gap = cnt_q >= 16'(T_RESET);

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= WAIT_RESET;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_RESET: if (!sync2_q && !rise && frame_gap) state_d = IDLE;
      IDLE:       if (rise) state_d = HIGH;
      HIGH: begin
        if (too_long)  state_d = WAIT_RESET;
        else if (fall) state_d = LOW;
      end
      LOW: begin
        if (rise)           state_d = HIGH;
        else if (frame_gap) state_d = IDLE;
      end
      default: state_d = WAIT_RESET;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bit_strb = 1'b0;
    eof_strb = 1'b0;
    long_err = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      HIGH: begin
        busy     = 1'b1;
        long_err = too_long;
        bit_strb = fall && !too_long;
      end
      LOW: begin
        busy     = 1'b1;
        eof_strb = !rise && frame_gap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q  <= 5'd0;
      word_cnt_q <= 8'd0;
      word_q     <= 24'd0;
      cap_q      <= 1'b0;
    end else begin
      cap_q <= bit_strb && (bit_cnt_q == 5'd23) && (word_cnt_q == 8'd0);
      if (bit_strb) begin
        word_q <= {word_q[22:0], (cnt_q > 16'(T_BIT_THRESH))};
        if (bit_cnt_q == 5'd23) begin
          bit_cnt_q <= 5'd0;
          if (word_cnt_q != 8'hFF) word_cnt_q <= word_cnt_q + 8'd1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 5'd1;
        end
      end else if (eof_strb || long_err) begin
        bit_cnt_q  <= 5'd0;
        word_cnt_q <= 8'd0;
        word_q     <= 24'd0;
      end
    end
  end

  // Colour registers take the first word only; cap_q lags the 24th bit by one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= 8'd0;
      g_q <= 8'd0;
      b_q <= 8'd0;
    end else if (cap_q) begin
      g_q <= word_q[23:16];
      r_q <= word_q[15:8];
      b_q <= word_q[7:0];
    end
  end

  assign st_clr = rx_cs && !R_W_n && (reg_addr_i == 2'd0);

  // Hardware set is OR-ed in after the clear so it wins a same-cycle collision.
  always_comb begin
    valid_d = valid_q & ~(st_clr & data_i[0]);
    err_d   = err_q   & ~(st_clr & data_i[1]);
    if (eof_strb && word_cnt_q != 8'd0)             valid_d = 1'b1;
    if (long_err || (eof_strb && bit_cnt_q != 5'd0)) err_d   = 1'b1;
  end

  always_comb begin
    data_d = 8'd0;
    unique case (reg_addr_i)
      2'd0: data_d = {5'd0, busy, err_q, valid_q};
      2'd1: data_d = r_q;
      2'd2: data_d = g_q;
      2'd3: data_d = b_q;
      default: data_d = 8'd0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 8'd0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign data_o = data_q;
  assign irq_o  = valid_q | err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: frames are bit-banged on the serial line and
// results are read back through the register page.
module tb_ws2812_rx;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       R_W_n = 1'b1;
  logic [1:0] reg_addr_i = 2'd0;
  logic [7:0] data_i = 8'd0;
  logic       rx_cs = 1'b0;
  logic       ws2812_in = 1'b0;
  logic [7:0] data_o;
  logic       irq_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  ws2812_rx dut (
    .clk_i(clk_i), .rst_i(rst_i), .R_W_n(R_W_n), .reg_addr_i(reg_addr_i),
    .data_i(data_i), .rx_cs(rx_cs), .ws2812_in(ws2812_in),
    .data_o(data_o), .irq_o(irq_o)
  );

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    reg_addr_i = a;
    tick(1);
    chk8(tag, data_o, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    R_W_n = 1'b0; rx_cs = 1'b1; reg_addr_i = a; data_i = d;
    tick(1);
    R_W_n = 1'b1; rx_cs = 1'b0; data_i = 8'd0;
  endtask

  task automatic send_bit(input logic b);
    ws2812_in = 1'b1; tick(b ? 21 : 10);
    ws2812_in = 1'b0; tick(b ? 10 : 21);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic low(input int n);
    ws2812_in = 1'b0; tick(n);
  endtask

  task automatic chk_rgb(input string tag, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
    rd_chk({tag, "_r"}, 2'd1, r);
    rd_chk({tag, "_g"}, 2'd2, g);
    rd_chk({tag, "_b"}, 2'd3, b);
  endtask

  initial begin
    // reset state
    tick(3);
    chk8("rst_data_o", data_o, 8'h00);
    chk1("rst_irq", irq_o, 1'b0);
    rst_i = 1'b0;
    rd_chk("rst_status", 2'd0, 8'h00);
    chk_rgb("rst", 8'h00, 8'h00, 8'h00);

    // 1: single word G=12 R=34 B=56
    low(1300);
    send_bits(24'h123456, 24);
    low(1300);
    chk_rgb("t1", 8'h34, 8'h12, 8'h56);
    rd_chk("t1_status", 2'd0, 8'h01);
    chk1("t1_irq", irq_o, 1'b1);

    // 2: W1C valid; writes to colour registers are ignored
    wr(2'd1, 8'hFF);
    wr(2'd0, 8'h01);
    chk1("t2_irq", irq_o, 1'b0);
    rd_chk("t2_status", 2'd0, 8'h00);
    rd_chk("t2_r_ro", 2'd1, 8'h34);

    // 3: three-word frame, only the first word lands
    send_bits(24'hA5A5A5, 24);
    send_bits(24'hFFFFFF, 24);
    send_bits(24'h000000, 24);
    low(1300);
    chk_rgb("t3", 8'hA5, 8'hA5, 8'hA5);
    rd_chk("t3_status", 2'd0, 8'h01);

    // 4: 30-bit frame: word captured, trailing partial flags error
    wr(2'd0, 8'h03);
    send_bits(24'h0F1E2D, 24);
    send_bits(24'hA80000, 6);
    low(1300);
    chk_rgb("t4", 8'h1E, 8'h0F, 8'h2D);
    rd_chk("t4_status", 2'd0, 8'h03);

    // 5: over-long high pulse, busy visible mid-pulse
    wr(2'd0, 8'h03);
    ws2812_in = 1'b1;
    tick(10);
    rd_chk("t5_busy", 2'd0, 8'h04);
    tick(49);
    low(1300);
    rd_chk("t5_status", 2'd0, 8'h02);
    chk1("t5_irq", irq_o, 1'b1);
    chk_rgb("t5_keep", 8'h1E, 8'h0F, 8'h2D);
    wr(2'd0, 8'h02);
    send_bits(24'hC33C81, 24);
    low(1300);
    chk_rgb("t5_clean", 8'h3C, 8'hC3, 8'h81);
    rd_chk("t5_clean_st", 2'd0, 8'h01);

    // 6: reset mid-word, release while the line keeps toggling
    send_bits(24'hABCDEF, 10);
    ws2812_in = 1'b1;
    rst_i = 1'b1;
    tick(3);
    chk8("t6_rst_data", data_o, 8'h00);
    chk1("t6_rst_irq", irq_o, 1'b0);
    tick(5);
    rst_i = 1'b0;
    tick(13);
    ws2812_in = 1'b0;
    tick(10);
    send_bits(24'hEF0000, 14);
    send_bits(24'hFFFFFF, 24);
    rd_chk("t6_tail_st", 2'd0, 8'h00);
    chk_rgb("t6_tail", 8'h00, 8'h00, 8'h00);
    chk1("t6_tail_irq", irq_o, 1'b0);
    low(1300);
    send_bits(24'h112233, 24);
    low(1300);
    chk_rgb("t6_after", 8'h22, 8'h11, 8'h33);
    rd_chk("t6_after_st", 2'd0, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
